// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer
//  Description : Moore FSM that sequences fetch / decode / execute for the
//                16-bit CPU. Drives the PC/RAM/IR unit and the register-file
//                / ALU datapath control strobes. Outputs are a pure function
//                of the current state; IR only steers the next state.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                      in   rising-edge clock
//    reset                    in   asynchronous reset, active low
//    IR[15:0]                 in   opc[15:13] op[12:11] Rn[10:8] Rd[7:5] Rm[2:0]
//    incp                     out  PC <= PC + 1
//    execb                    out  evaluate branch condition, take if true
//    msel                     out  1: RAM address = C[7:0], 0: RAM address = PC
//    mwrite                   out  RAM write strobe
//    loadir                   out  IR <= mdata
//    loada/loadb/loadc/loads  out  datapath register enables (loads = status)
//    asel                     out  ALU A input forced to zero
//    bsel                     out  ALU B input = sximm5
//    write                    out  register-file write
//    nsel[2:0]                out  one-hot register select: 001 Rn, 010 Rd, 100 Rm
//    vsel[1:0]                out  writeback source: 00 C, 01 sximm8, 10 mdata, 11 PC
//    halted                   out  high while in HALT
// ============================================================================
module instr_sequencer #(
  parameter int unsigned RAM_LAT    = 1,    // RAM read latency, 1..3
  parameter bit          UNDEF_HALT = 1'b1  // undefined opcode halts when set
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IR,
  output logic        incp,
  output logic        execb,
  output logic        msel,
  output logic        mwrite,
  output logic        loadir,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        write,
  output logic [2:0]  nsel,
  output logic [1:0]  vsel,
  output logic        halted
);

  localparam logic [4:0] F_ADDR   = 5'd0;
  localparam logic [4:0] F_WAIT   = 5'd1;
  localparam logic [4:0] F_LOAD   = 5'd2;
  localparam logic [4:0] DECODE   = 5'd3;
  localparam logic [4:0] W_IMM    = 5'd4;
  localparam logic [4:0] GET_A    = 5'd5;
  localparam logic [4:0] GET_B    = 5'd6;
  localparam logic [4:0] EXEC     = 5'd7;
  localparam logic [4:0] EXEC_CMP = 5'd8;
  localparam logic [4:0] EXEC_MVN = 5'd9;
  localparam logic [4:0] W_REG    = 5'd10;
  localparam logic [4:0] ADDR     = 5'd11;
  localparam logic [4:0] M_RD     = 5'd12;
  localparam logic [4:0] M_WAIT   = 5'd13;
  localparam logic [4:0] W_MEM    = 5'd14;
  localparam logic [4:0] GET_D    = 5'd15;
  localparam logic [4:0] M_WR     = 5'd16;
  localparam logic [4:0] BRANCH   = 5'd17;
  localparam logic [4:0] HALT     = 5'd18;

  // The wait counter starts at 0 on entry, so the last wait cycle has
  // count RAM_LAT-2. With RAM_LAT=1 the wait states are never entered.
  localparam bit         HAS_WAIT  = (RAM_LAT > 1);
  localparam logic [1:0] WAIT_LAST = HAS_WAIT ? 2'(RAM_LAT - 2) : 2'd0;

  logic [4:0] state_q, state_d;
  logic [1:0] wcnt_q,  wcnt_d;

  logic [2:0] opc;
  logic [1:0] op;
  logic       unused_ir;

  assign opc       = IR[15:13];
  assign op        = IR[12:11];
  assign unused_ir = ^IR[10:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= F_ADDR;
      wcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state logic. IR is held stable by the datapath for the whole
  // instruction, so later phases may look at it again to pick a branch.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      F_ADDR: begin
        wcnt_d  = 2'd0;
        state_d = HAS_WAIT ? F_WAIT : F_LOAD;
      end
      F_WAIT: begin
        if (wcnt_q == WAIT_LAST) state_d = F_LOAD;
        else                     wcnt_d  = wcnt_q + 2'd1;
      end
      F_LOAD: state_d = DECODE;
      DECODE: begin
        case (opc)
          3'b110:  state_d = W_IMM;
          3'b101:  state_d = GET_A;
          3'b011:  state_d = GET_A;
          3'b100:  state_d = GET_A;
          3'b001:  state_d = BRANCH;
          3'b111:  state_d = HALT;
          default: state_d = UNDEF_HALT ? HALT : F_ADDR;
        endcase
      end
      W_IMM: state_d = F_ADDR;
      GET_A: state_d = (opc == 3'b101) ? GET_B : ADDR;
      // CMP and MVN get their own execute states so the status load and
      // the A-input override stay decoded from state alone.
      GET_B: begin
        case (op)
          2'b01:   state_d = EXEC_CMP;
          2'b11:   state_d = EXEC_MVN;
          default: state_d = EXEC;
        endcase
      end
      EXEC:     state_d = W_REG;
      EXEC_MVN: state_d = W_REG;
      EXEC_CMP: state_d = F_ADDR;
      W_REG:    state_d = F_ADDR;
      ADDR:     state_d = (opc == 3'b011) ? M_RD : GET_D;
      M_RD: begin
        wcnt_d  = 2'd0;
        state_d = HAS_WAIT ? M_WAIT : W_MEM;
      end
      M_WAIT: begin
        if (wcnt_q == WAIT_LAST) state_d = W_MEM;
        else                     wcnt_d  = wcnt_q + 2'd1;
      end
      W_MEM:  state_d = F_ADDR;
      GET_D:  state_d = M_WR;
      M_WR:   state_d = F_ADDR;
      BRANCH: state_d = F_ADDR;
      HALT:   state_d = HALT;
      default: state_d = F_ADDR;
    endcase
  end

  // Moore output decode: everything defaults low.
  always_comb begin
    incp   = 1'b0;
    execb  = 1'b0;
    msel   = 1'b0;
    mwrite = 1'b0;
    loadir = 1'b0;
    loada  = 1'b0;
    loadb  = 1'b0;
    loadc  = 1'b0;
    loads  = 1'b0;
    asel   = 1'b0;
    bsel   = 1'b0;
    write  = 1'b0;
    nsel   = 3'b000;
    vsel   = 2'b00;
    halted = 1'b0;
    case (state_q)
      F_LOAD: begin
        loadir = 1'b1;
        incp   = 1'b1;
      end
      W_IMM: begin
        write = 1'b1;
        nsel  = 3'b001;
        vsel  = 2'b01;
      end
      GET_A: begin
        loada = 1'b1;
        nsel  = 3'b001;
      end
      GET_B: begin
        loadb = 1'b1;
        nsel  = 3'b100;
      end
      EXEC:     loadc = 1'b1;
      EXEC_CMP: begin
        loadc = 1'b1;
        loads = 1'b1;
      end
      EXEC_MVN: begin
        loadc = 1'b1;
        asel  = 1'b1;
      end
      W_REG: begin
        write = 1'b1;
        nsel  = 3'b010;
      end
      ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      M_RD:   msel = 1'b1;
      M_WAIT: msel = 1'b1;
      W_MEM: begin
        msel  = 1'b1;
        write = 1'b1;
        vsel  = 2'b10;
        nsel  = 3'b010;
      end
      GET_D: begin
        loadb = 1'b1;
        nsel  = 3'b010;
      end
      M_WR: begin
        msel   = 1'b1;
        mwrite = 1'b1;
      end
      BRANCH: execb  = 1'b1;
      HALT:   halted = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_sequencer
//  Description : Directed table-driven bench for instr_sequencer. One instance
//                with RAM_LAT=1/UNDEF_HALT=1, one with RAM_LAT=3/UNDEF_HALT=0.
//                Output vector layout (bit 17 down to 0):
//                halted incp execb msel mwrite loadir loada loadb loadc loads
//                asel bsel write nsel[2:0] vsel[1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

  localparam logic [17:0] HLT = 18'h20000;
  localparam logic [17:0] INC = 18'h10000;
  localparam logic [17:0] EXB = 18'h08000;
  localparam logic [17:0] MSL = 18'h04000;
  localparam logic [17:0] MWR = 18'h02000;
  localparam logic [17:0] LIR = 18'h01000;
  localparam logic [17:0] LDA = 18'h00800;
  localparam logic [17:0] LDB = 18'h00400;
  localparam logic [17:0] LDC = 18'h00200;
  localparam logic [17:0] LDS = 18'h00100;
  localparam logic [17:0] ASL = 18'h00080;
  localparam logic [17:0] BSL = 18'h00040;
  localparam logic [17:0] WR  = 18'h00020;
  localparam logic [17:0] NRM = 18'h00010;
  localparam logic [17:0] NRD = 18'h00008;
  localparam logic [17:0] NRN = 18'h00004;
  localparam logic [17:0] VIM = 18'h00001;
  localparam logic [17:0] VMD = 18'h00002;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1_n, rst3_n;
  logic [15:0] ir1, ir3;

  logic       incp1, execb1, msel1, mwrite1, loadir1, loada1, loadb1, loadc1;
  logic       loads1, asel1, bsel1, write1, halted1;
  logic [2:0] nsel1;
  logic [1:0] vsel1;
  logic       incp3, execb3, msel3, mwrite3, loadir3, loada3, loadb3, loadc3;
  logic       loads3, asel3, bsel3, write3, halted3;
  logic [2:0] nsel3;
  logic [1:0] vsel3;

  instr_sequencer #(.RAM_LAT(1), .UNDEF_HALT(1'b1)) u_dut1 (
    .clk(clk), .reset(rst1_n), .IR(ir1),
    .incp(incp1), .execb(execb1), .msel(msel1), .mwrite(mwrite1),
    .loadir(loadir1), .loada(loada1), .loadb(loadb1), .loadc(loadc1),
    .loads(loads1), .asel(asel1), .bsel(bsel1), .write(write1),
    .nsel(nsel1), .vsel(vsel1), .halted(halted1)
  );

  instr_sequencer #(.RAM_LAT(3), .UNDEF_HALT(1'b0)) u_dut3 (
    .clk(clk), .reset(rst3_n), .IR(ir3),
    .incp(incp3), .execb(execb3), .msel(msel3), .mwrite(mwrite3),
    .loadir(loadir3), .loada(loada3), .loadb(loadb3), .loadc(loadc3),
    .loads(loads3), .asel(asel3), .bsel(bsel3), .write(write3),
    .nsel(nsel3), .vsel(vsel3), .halted(halted3)
  );

  logic [17:0] o1, o3;
  assign o1 = {halted1, incp1, execb1, msel1, mwrite1, loadir1, loada1, loadb1,
               loadc1, loads1, asel1, bsel1, write1, nsel1, vsel1};
  assign o3 = {halted3, incp3, execb3, msel3, mwrite3, loadir3, loada3, loadb3,
               loadc3, loads3, asel3, bsel3, write3, nsel3, vsel3};

  typedef struct {
    bit          sel;   // 0: u_dut1, 1: u_dut3
    logic [15:0] ir;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input bit s, input logic [15:0] ir, input logic [17:0] e);
    vec_t v;
    v.sel = s;
    v.ir  = ir;
    v.exp = e;
    tbl.push_back(v);
  endtask

  // F_ADDR, fetch waits, F_LOAD, DECODE
  task automatic fetch(input bit s, input logic [15:0] ir);
    int lat;
    lat = s ? 3 : 1;
    push(s, ir, 18'h0);
    for (int k = 1; k < lat; k++) push(s, ir, 18'h0);
    push(s, ir, INC | LIR);
    push(s, ir, 18'h0);
  endtask

  task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %05h expected %05h", nm, act, exp);
    end
  endtask

  // One row per clock: drive IR, compare outputs, advance one cycle.
  task automatic run(input bit s);
    int row;
    row = 0;
    foreach (tbl[i]) begin
      if (tbl[i].sel == s) begin
        if (s) ir3 = tbl[i].ir;
        else   ir1 = tbl[i].ir;
        check($sformatf("dut%0d_row%0d_ir%04h", s ? 3 : 1, row, tbl[i].ir),
              s ? o3 : o1, tbl[i].exp);
        row++;
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    // ---------------- RAM_LAT=1 table ----------------
    fetch(0, 16'hD205); push(0, 16'hD205, WR | NRN | VIM);               // MOV
    fetch(0, 16'hA061); push(0, 16'hA061, LDA | NRN);                    // ADD
    push(0, 16'hA061, LDB | NRM); push(0, 16'hA061, LDC);
    push(0, 16'hA061, WR | NRD);
    fetch(0, 16'hA801); push(0, 16'hA801, LDA | NRN);                    // CMP
    push(0, 16'hA801, LDB | NRM); push(0, 16'hA801, LDC | LDS);
    fetch(0, 16'hB861); push(0, 16'hB861, LDA | NRN);                    // MVN
    push(0, 16'hB861, LDB | NRM); push(0, 16'hB861, LDC | ASL);
    push(0, 16'hB861, WR | NRD);
    fetch(0, 16'h6040); push(0, 16'h6040, LDA | NRN);                    // LDR
    push(0, 16'h6040, BSL | LDC); push(0, 16'h6040, MSL);
    push(0, 16'h6040, MSL | WR | VMD | NRD);
    fetch(0, 16'h8040); push(0, 16'h8040, LDA | NRN);                    // STR
    push(0, 16'h8040, BSL | LDC); push(0, 16'h8040, LDB | NRD);
    push(0, 16'h8040, MSL | MWR);
    fetch(0, 16'h2000); push(0, 16'h2000, EXB);                          // B
    fetch(0, 16'hE000); push(0, 16'hE000, HLT);                          // HALT

    // ---------------- RAM_LAT=3 table ----------------
    fetch(1, 16'h6040); push(1, 16'h6040, LDA | NRN);                    // LDR
    push(1, 16'h6040, BSL | LDC); push(1, 16'h6040, MSL);
    push(1, 16'h6040, MSL); push(1, 16'h6040, MSL);
    push(1, 16'h6040, MSL | WR | VMD | NRD);
    fetch(1, 16'h0000);                                                  // undefined -> NOP
    fetch(1, 16'h8040); push(1, 16'h8040, LDA | NRN);                    // STR
    push(1, 16'h8040, BSL | LDC); push(1, 16'h8040, LDB | NRD);
    push(1, 16'h8040, MSL | MWR); push(1, 16'h8040, 18'h0);

    rst1_n = 1'b0;
    rst3_n = 1'b0;
    ir1    = 16'h0000;
    ir3    = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset_dut1", o1, 18'h0);
    check("reset_dut3", o3, 18'h0);

    @(negedge clk);
    rst1_n = 1'b1;
    #1;
    run(0);

    // HALT holds with no fetch activity
    for (int k = 0; k < 20; k++) begin
      check($sformatf("halt_hold%0d", k), o1, HLT);
      @(posedge clk);
      #1;
    end

    // Reset asserted in the middle of EXEC
    @(negedge clk);
    rst1_n = 1'b0;
    @(negedge clk);
    ir1    = 16'hA061;
    rst1_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_exec", o1, LDC);
    #2;
    rst1_n = 1'b0;
    #1;
    check("async_reset_exec", o1, 18'h0);
    @(negedge clk);
    rst1_n = 1'b1;
    #1;
    check("post_reset_faddr", o1, 18'h0);
    @(posedge clk);
    #1;
    check("post_reset_fload", o1, INC | LIR);

    // Undefined opcode halts when UNDEF_HALT=1
    @(negedge clk);
    rst1_n = 1'b0;
    ir1    = 16'h0000;
    @(negedge clk);
    rst1_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("undef_halt", o1, HLT);

    // Switch to the RAM_LAT=3 instance
    @(negedge clk);
    rst1_n = 1'b0;
    rst3_n = 1'b1;
    #1;
    run(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
